// File: rtl/vc_input_buffer_pkg.sv
// Shared defaults and helpers for the two-VC input buffer.
// The VC select bit is always the top bit of the packet.
package vc_input_buffer_pkg;

  localparam int DATA_WIDTH_DEF = 5;
  localparam int DEPTH_DEF      = 4;
  localparam int AF_THRESH_DEF  = 3;
  localparam int AE_THRESH_DEF  = 1;
  localparam int VC_SEL_BIT_DEF = DATA_WIDTH_DEF - 1;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_id_e;

  function automatic int vc_sel_bit(input int data_width);
    return data_width - 1;
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single show-ahead FIFO with occupancy flags and one-cycle overflow/underflow pulses.
// Storage is not reset; the head output is forced to zero while empty.
module vc_fifo
  import vc_input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign data_out     = empty ? '0 : mem_q[rd_ptr_q];

  // push/pop are single-cycle strobes with no back-pressure: a pop takes effect
  // only when non-empty, a push only when not full or when the same FIFO pops.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/vc_input_buffer.sv
// Two-VC input buffer: demuxes incoming packets by their top bit into two FIFOs
// and keeps a sticky error flag for any overflow or underflow.
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF,
  parameter int AE_THRESH  = AE_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  pushIn,
  input  logic                  popVC0,
  input  logic                  popVC1,
  output logic [DATA_WIDTH-1:0] VC0_out,
  output logic [DATA_WIDTH-1:0] VC1_out,
  output logic                  emptyVC0,
  output logic                  emptyVC1,
  output logic                  fullVC0,
  output logic                  fullVC1,
  output logic                  almostFullVC0,
  output logic                  almostFullVC1,
  output logic                  almostEmptyVC0,
  output logic                  almostEmptyVC1,
  output logic                  error
);

  localparam int SEL = vc_sel_bit(DATA_WIDTH);

  logic push_vc0, push_vc1;
  logic ovf_vc0, ovf_vc1, unf_vc0, unf_vc1;
  logic error_q, error_d;

  assign push_vc0 = pushIn && (dataIn[SEL] == VC0);
  assign push_vc1 = pushIn && (dataIn[SEL] == VC1);

  vc_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) u_fifo_vc0 (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push_vc0),
    .pop         (popVC0),
    .data_in     (dataIn),
    .data_out    (VC0_out),
    .empty       (emptyVC0),
    .full        (fullVC0),
    .almost_full (almostFullVC0),
    .almost_empty(almostEmptyVC0),
    .overflow    (ovf_vc0),
    .underflow   (unf_vc0)
  );

  vc_fifo #(
    .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) u_fifo_vc1 (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push_vc1),
    .pop         (popVC1),
    .data_in     (dataIn),
    .data_out    (VC1_out),
    .empty       (emptyVC1),
    .full        (fullVC1),
    .almost_full (almostFullVC1),
    .almost_empty(almostEmptyVC1),
    .overflow    (ovf_vc1),
    .underflow   (unf_vc1)
  );

  assign error_d = error_q | ovf_vc0 | ovf_vc1 | unf_vc0 | unf_vc1;
  assign error   = error_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) error_q <= 1'b0;
    else          error_q <= error_d;
  end

endmodule
